// File: rtl/common_pkg.sv
// Shared types and constants for the write-back stage.
//   ma_size_t  : memory access size / signedness
//   wb_state_t : write-back load-wait FSM states
//   NOP_PC     : program counter value marking a pipeline bubble
//   NOP_IR     : instruction word carried by a bubble (addi x0, x0, 0)
package common;

    typedef enum logic [2:0] {
        MA_B  = 3'd0,
        MA_H  = 3'd1,
        MA_W  = 3'd2,
        MA_BU = 3'd3,
        MA_HU = 3'd4
    } ma_size_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_t;

    // An odd PC can never be fetched, so it safely marks a bubble.
    localparam logic [31:0] NOP_PC = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_IR = 32'h0000_0013;

endpackage

// File: rtl/cpu_load_align.sv
// Combinational load-data extraction.
//   word_i     : aligned data-memory read word
//   addr_i     : low two bits of the byte address
//   size_i     : access size / signedness
//   data_o     : extracted, sign/zero-extended value (0 when misaligned)
//   misalign_o : access is misaligned for its size
module cpu_load_align
    import common::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  ma_size_t    size_i,
    output logic [31:0] data_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o     = 32'b0;
        misalign_o = 1'b0;
        case (size_i)
            MA_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            MA_BU: data_o = {24'b0, byte_sel};
            MA_H, MA_HU: begin
                if (addr_i[0]) begin
                    misalign_o = 1'b1;
                end else if (size_i == MA_H) begin
                    data_o = {{16{half_sel[15]}}, half_sel};
                end else begin
                    data_o = {16'b0, half_sel};
                end
            end
            MA_W: begin
                if (addr_i != 2'd0) begin
                    misalign_o = 1'b1;
                end else begin
                    data_o = word_i;
                end
            end
            default: begin
                data_o     = 32'b0;
                misalign_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_wb.sv
// Write-back stage: aligns load data, commits to the register file through
// a registered write port, counts retired instructions, provides bypass
// values and stalls upstream while load read data is outstanding.
//   clk_i, reset_i          : clock, async active-high reset
//   pc_i, ir_i              : instruction in this stage (pc_i == NOP_PC is a bubble)
//   load_i, ma_size_i       : load flag and access size
//   wb_data_i, wb_valid_i   : result (byte address for loads) and rd-write flag
//   dmem_read_*_i           : data-memory read word and its valid
//   wb_*_async_o            : combinational bypass to decode/hazard logic
//   stall_async_o           : hold upstream stages
//   empty_async_o           : stage holds a bubble
//   rf_write_*_o            : registered register-file write port
//   misalign_o, retired_o   : registered one-cycle retire pulses
//   instret_o               : retired-instruction counter
//
// state   | meaning
// WB_IDLE | no load outstanding
// WB_WAIT | load held in stage, waiting for dmem_read_valid_i
module cpu_wb
    import common::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] ir_i,
    input  logic        load_i,
    input  ma_size_t    ma_size_i,
    input  logic [31:0] wb_data_i,
    input  logic        wb_valid_i,
    input  logic [31:0] dmem_read_data_i,
    input  logic        dmem_read_valid_i,
    output logic [4:0]  wb_addr_async_o,
    output logic [31:0] wb_data_async_o,
    output logic        wb_valid_async_o,
    output logic        stall_async_o,
    output logic        empty_async_o,
    output logic [4:0]  rf_write_addr_o,
    output logic [31:0] rf_write_data_o,
    output logic        rf_write_enable_o,
    output logic        misalign_o,
    output logic        retired_o,
    output logic [63:0] instret_o
);

    wb_state_t   state, state_next;
    logic [31:0] load_data;
    logic        load_misalign;
    logic        commit;
    logic [4:0]  rd;
    logic        unused_ir;

    assign rd        = ir_i[11:7];
    assign unused_ir = ^{ir_i[31:12], ir_i[6:0]};

    cpu_load_align u_align (
        .word_i     (dmem_read_data_i),
        .addr_i     (wb_data_i[1:0]),
        .size_i     (ma_size_i),
        .data_o     (load_data),
        .misalign_o (load_misalign)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= WB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        stall_async_o = 1'b0;
        case (state)
            WB_IDLE: begin
                if (load_i && !dmem_read_valid_i && !empty_async_o) begin
                    stall_async_o = 1'b1;
                    state_next    = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (!dmem_read_valid_i) begin
                    stall_async_o = 1'b1;
                end else begin
                    state_next = WB_IDLE;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    assign empty_async_o    = (pc_i == NOP_PC);
    assign commit           = !empty_async_o && !stall_async_o;
    assign wb_addr_async_o  = rd;
    assign wb_data_async_o  = load_i ? load_data : wb_data_i;
    assign wb_valid_async_o = wb_valid_i && !stall_async_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rf_write_addr_o   <= 5'd0;
            rf_write_data_o   <= 32'd0;
            rf_write_enable_o <= 1'b0;
            retired_o         <= 1'b0;
            misalign_o        <= 1'b0;
            instret_o         <= 64'd0;
        end else if (commit) begin
            rf_write_addr_o   <= rd;
            rf_write_data_o   <= wb_data_async_o;
            rf_write_enable_o <= wb_valid_i && (rd != 5'd0);
            retired_o         <= 1'b1;
            misalign_o        <= load_i && load_misalign;
            instret_o         <= instret_o + 64'd1;
        end else begin
            rf_write_enable_o <= 1'b0;
            retired_o         <= 1'b0;
            misalign_o        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_wb.sv
module tb_cpu_wb;
    import common::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = NOP_PC;
    logic [31:0] ir = NOP_IR;
    logic        load = 1'b0;
    ma_size_t    size = MA_W;
    logic [31:0] wdata = 32'd0;
    logic        wvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        rvalid = 1'b0;

    logic [4:0]  byp_addr;
    logic [31:0] byp_data;
    logic        byp_valid, stall, empty;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        rf_en, mis, ret;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    cpu_wb dut (
        .clk_i             (clk),
        .reset_i           (rst),
        .pc_i              (pc),
        .ir_i              (ir),
        .load_i            (load),
        .ma_size_i         (size),
        .wb_data_i         (wdata),
        .wb_valid_i        (wvalid),
        .dmem_read_data_i  (rdata),
        .dmem_read_valid_i (rvalid),
        .wb_addr_async_o   (byp_addr),
        .wb_data_async_o   (byp_data),
        .wb_valid_async_o  (byp_valid),
        .stall_async_o     (stall),
        .empty_async_o     (empty),
        .rf_write_addr_o   (rf_addr),
        .rf_write_data_o   (rf_data),
        .rf_write_enable_o (rf_en),
        .misalign_o        (mis),
        .retired_o         (ret),
        .instret_o         (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference extraction written from the access rules with plain arithmetic.
    function automatic logic [32:0] ref_ext(input logic [31:0] word, input logic [1:0] a,
                                            input ma_size_t sz);
        logic [31:0] v;
        v = 32'd0;
        if (sz == MA_B || sz == MA_BU) begin
            v = (word >> (8 * a)) & 32'hFF;
            if (sz == MA_B && v >= 32'd128) v = v + 32'hFFFF_FF00;
            return {1'b0, v};
        end
        if (sz == MA_H || sz == MA_HU) begin
            if (a % 2 != 0) return {1'b1, 32'd0};
            v = (word >> (16 * (a / 2))) & 32'hFFFF;
            if (sz == MA_H && v >= 32'h8000) v = v + 32'hFFFF_0000;
            return {1'b0, v};
        end
        if (a != 2'd0) return {1'b1, 32'd0};
        return {1'b0, word};
    endfunction

    // Model: a live instruction waits whenever it is a load without its data.
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_en, m_ret, m_mis;
    logic [63:0] m_instret;
    logic        chk_en = 1'b0;

    function automatic logic m_waiting();
        return (pc != NOP_PC) && load && !rvalid;
    endfunction

    function automatic logic [32:0] m_result();
        if (load) return ref_ext(rdata, wdata[1:0], size);
        return {1'b0, wdata};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr = 0; m_data = 0; m_en = 0; m_ret = 0; m_mis = 0; m_instret = 0;
        end else if (pc != NOP_PC && !m_waiting()) begin
            logic [32:0] r;
            r = m_result();
            m_addr = ir[11:7];
            m_data = r[31:0];
            m_en = wvalid && (ir[11:7] != 5'd0);
            m_ret = 1'b1;
            m_mis = r[32];
            m_instret = m_instret + 64'd1;
        end else begin
            m_en = 0; m_ret = 0; m_mis = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            logic [32:0] r;
            r = m_result();
            check("byp_addr", 64'(byp_addr), 64'(ir[11:7]));
            check("stall", 64'(stall), 64'(m_waiting()));
            check("empty", 64'(empty), 64'(pc == NOP_PC));
            check("byp_valid", 64'(byp_valid), 64'(wvalid && !m_waiting()));
            if (!m_waiting()) check("byp_data", 64'(byp_data), 64'(r[31:0]));
            check("rf_addr", 64'(rf_addr), 64'(m_addr));
            check("rf_data", 64'(rf_data), 64'(m_data));
            check("rf_en", 64'(rf_en), 64'(m_en));
            check("retired", 64'(ret), 64'(m_ret));
            check("misalign", 64'(mis), 64'(m_mis));
            check("instret", instret, m_instret);
        end
    end

    task automatic set_in(input logic [31:0] p, input logic [4:0] rd, input logic ld,
                          input ma_size_t sz, input logic [31:0] d, input logic v,
                          input logic [31:0] rw, input logic rv);
        pc = p; ir = {20'd0, rd, 7'h13}; load = ld; size = sz;
        wdata = d; wvalid = v; rdata = rw; rvalid = rv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        pc = NOP_PC; ir = NOP_IR; load = 0; wvalid = 0; rvalid = 0;
    endtask

    int stall_cnt;

    initial begin
        #1;
        check("rst_rf_en", 64'(rf_en), 0);
        check("rst_instret", instret, 0);
        check("rst_rf_data", 64'(rf_data), 0);
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // ALU op to x5
        set_in(32'h100, 5'd5, 0, MA_W, 32'h1234, 1, 32'd0, 0);
        tick();
        check("alu_addr", 64'(rf_addr), 5);
        check("alu_data", 64'(rf_data), 64'h1234);
        check("alu_en", 64'(rf_en), 1);
        check("alu_instret", instret, 1);

        // Signed byte, lane 3, data present immediately
        set_in(32'h104, 5'd6, 1, MA_B, 32'h1003, 1, 32'h80FF_FF00, 1);
        #1 check("lb_nostall", 64'(stall), 0);
        tick();
        check("lb_data", 64'(rf_data), 64'hFFFF_FF80);

        set_in(32'h108, 5'd7, 1, MA_BU, 32'h1003, 1, 32'h80FF_FF00, 1);
        tick();
        check("lbu_data", 64'(rf_data), 64'h0000_0080);

        // Signed half, three-cycle memory delay
        set_in(32'h10C, 5'd8, 1, MA_H, 32'h2002, 1, 32'hDEAD_DEAD, 0);
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall) stall_cnt++;
            check("lh_byp_valid_stalled", 64'(byp_valid), 0);
            tick();
            check("lh_no_write_stalled", 64'(rf_en), 0);
        end
        rdata = 32'hBEEF_0000; rvalid = 1;
        #1 check("lh_stall_released", 64'(stall), 0);
        check("lh_byp_data", 64'(byp_data), 64'hFFFF_BEEF);
        check("lh_stall_cycles", 64'(stall_cnt), 3);
        tick();
        check("lh_data", 64'(rf_data), 64'hFFFF_BEEF);
        check("lh_instret", instret, 4);

        // Misaligned word
        set_in(32'h110, 5'd9, 1, MA_W, 32'h3001, 1, 32'h1234_5678, 1);
        tick();
        check("lw_mis_data", 64'(rf_data), 0);
        check("lw_mis_flag", 64'(mis), 1);
        check("lw_mis_ret", 64'(ret), 1);

        // rd = x0 still retires
        set_in(32'h114, 5'd0, 0, MA_W, 32'h55, 1, 32'd0, 0);
        tick();
        check("x0_en", 64'(rf_en), 0);
        check("x0_ret", 64'(ret), 1);
        check("mis_pulse_end", 64'(mis), 0);

        // Bubble
        bubble();
        #1 check("bubble_empty", 64'(empty), 1);
        tick();
        check("bubble_ret", 64'(ret), 0);

        // Stray read-valid on a non-load is ignored
        set_in(32'h118, 5'd10, 0, MA_B, 32'hCAFE_0003, 1, 32'hFFFF_FFFF, 1);
        tick();
        check("stray_valid_data", 64'(rf_data), 64'hCAFE_0003);

        // Reset while waiting
        set_in(32'h11C, 5'd11, 1, MA_W, 32'h4000, 1, 32'd0, 0);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_wait_instret", instret, 0);
        check("rst_wait_rf_data", 64'(rf_data), 0);
        check("rst_wait_rf_addr", 64'(rf_addr), 0);
        bubble();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_en", 64'(rf_en), 0);
        check("post_rst_ret", 64'(ret), 0);
        check("post_rst_instret", instret, 0);

        set_in(32'h120, 5'd12, 1, MA_HU, 32'h5002, 1, 32'h8001_0000, 1);
        #1 check("post_rst_idle", 64'(stall), 0);
        tick();
        check("lhu_data", 64'(rf_data), 64'h0000_8001);
        check("lhu_instret", instret, 1);

        bubble();
        tick(); tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cpu_wb.md
# cpu_wb

Write-back stage of the pipelined RISC-V core, directly downstream of the memory-access stage. It consumes the registered memory-access outputs and data-memory read data, then aligns and sign/zero-extends load results. It commits results to the register file through a registered write port and counts retired instructions. It also presents combinational bypass values to the decode/hazard logic and stalls upstream while a load's read data is outstanding.

## Interface
- No parameters.
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- pc_i  in  32  program counter (NOP_PC = bubble)
- ir_i  in  32  instruction register; rd = ir_i[11:7]
- load_i  in  1  instruction is a load
- ma_size_i  in  ma_size_t  access size/signedness
- wb_data_i  in  32  write-back data; for loads, the byte address
- wb_valid_i  in  1  instruction writes rd
- dmem_read_data_i  in  32  aligned data-memory read word
- dmem_read_valid_i  in  1  read word valid this cycle
- wb_addr_async_o  out  5  bypass rd
- wb_data_async_o  out  32  bypass value (extended load data when valid)
- wb_valid_async_o  out  1  bypass value usable
- stall_async_o  out  1  hold upstream stages
- empty_async_o  out  1  pc_i == NOP_PC
- rf_write_addr_o  out  5  register-file write address
- rf_write_data_o  out  32  register-file write data
- rf_write_enable_o  out  1  register-file write strobe
- misalign_o  out  1  misaligned load retired (pulse)
- retired_o  out  1  instruction retired (pulse)
- instret_o  out  64  retired-instruction count

## Operation
- Load extraction, with byte lane from wb_data_i[1:0]:
  - B/BU select byte lane (addr×8) and sign/zero-extend.
  - H/HU select the half at addr[1] and extend.
  - W uses the whole word.
  - Halfword with addr[0]=1, or word with addr[1:0]≠0, yields 32'b0 and sets misalign_o.
- Non-load result = wb_data_i unchanged.
- FSM states: IDLE and WAIT.
  - IDLE with load_i and !dmem_read_valid_i, and pc_i≠NOP_PC: go to WAIT, stall_async_o=1.
  - WAIT with !dmem_read_valid_i: stay, stall=1.
  - WAIT with dmem_read_valid_i: commit, go to IDLE, stall=0.
  - Load with valid already present in IDLE commits the same cycle with no stall.
- Upstream holds all inputs stable while stall_async_o=1.
- Commit happens on a cycle where the stage holds a non-bubble and stall_async_o=0:
  - rf_write_enable_o ← wb_valid_i && rd≠0.
  - retired_o ← 1.
  - instret_o increments, wrapping from 2^64−1 to 0.
- A bubble or stalled cycle gives rf_write_enable_o=0 and retired_o=0.
- Bypass behaviour:
  - wb_valid_async_o = wb_valid_i && !stall_async_o.
  - wb_data_async_o carries the extended value in the same cycle the read data arrives.

## Timing
- Combinational paths: bypass outputs and stall_async_o are combinational from inputs and state.
- Registered outputs, updated 1 cycle after commit: rf_write_*, retired_o, misalign_o, instret_o.
- Load latency: N-cycle dmem delay gives N stall cycles, and the RF write lands 1 cycle after valid.
- Reset is asynchronous and takes precedence over everything.
- Reset values:
  - state=IDLE
  - rf_write_addr_o=0, rf_write_data_o=0, rf_write_enable_o=0
  - retired_o=0, misalign_o=0
  - instret_o=0
- Reset while in WAIT: the pending load is dropped with no write and no count.
- dmem_read_valid_i asserted on a non-load cycle is ignored.

## Structure
- Package `common` holds:
  - ma_size_t (B, H, W, BU, HU)
  - NOP_PC, NOP_IR
  - a wb_state_t enum (WB_IDLE, WB_WAIT)
- One sub-module: `cpu_load_align`, purely combinational. Inputs are word, addr[1:0] and ma_size_t; outputs are the extended value and a misalign flag.

## Test plan
- ALU op, rd=x5, wb_data_i=0x1234, wb_valid_i=1 → next cycle rf_write addr 5 / data 0x1234 / enable=1, instret 0→1.
- Load, size B, addr ending 0b11, read data 0x80FF_FF00, valid the same cycle → no stall, writes 0xFFFFFF80; size BU instead → 0x00000080.
- Load, size H, addr ending 0b10, valid after 3 cycles:
  - stall_async_o high for exactly 3 cycles.
  - data 0xBEEF_0000 → writes 0xFFFFBEEF.
  - wb_valid_async_o is 0 while stalled.
- Load, size W, addr ending 0b01 → writes 0, misalign_o pulses, retired_o pulses.
- rd=x0 with wb_valid_i=1 → enable=0 but retired_o=1; a bubble (pc=NOP_PC) → no retire and empty_async_o=1.
- Reset asserted mid-WAIT → all outputs and instret_o 0 immediately, state IDLE, no write after release.
